turbo_block_interleaver: RTL
============================

# turbo_block_interleaver

Parametrised ping-pong row/column block interleaver/deinterleaver for the turbo decoder's extrinsic path. Each beat carries LANES soft values of W bits. A frame of ROWS×COLS beats is buffered and released in permuted beat order, and every beat also gets the bit-reversed lane permutation. With LANES=4, that lane permutation is the middle-lane swap used between the component decoders. Two banks let one frame be written while the previous frame drains, sustaining one beat per cycle.

## Interface
- W, 30, soft-value width in bits
- LANES, 4, lanes per beat; power of two, ≥2
- ROWS, 2, interleaver rows
- COLS, 3, interleaver columns; frame length DEPTH = ROWS*COLS beats
- LANE_PERM, 1, 1 = apply bit-reversed lane permutation, 0 = lanes pass straight through
- Reset is rst, synchronous, active-low; clock is clk.
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- mode  in  1  0 = interleave, 1 = deinterleave; sampled on the first beat of each frame
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid and in_ready are both high
- in_data  in  LANES*W  lane i occupies bits [i*W+W-1 : i*W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  LANES*W  permuted beat
- out_last  out  1  high on the last beat of a frame

## Operation
- **Bank states.** Each bank holds one state: EMPTY, FILL, FULL or DRAIN.
  - A write pointer selects the bank being filled.
  - A read pointer selects the bank being drained.
  - Both pointers toggle on frame completion.
- **Write side.**
  - in_ready = 1 when the write bank is EMPTY or FILL.
  - Accepted beat k (0..DEPTH-1) is stored at address k; the write counter then increments.
  - On k=0 the bank goes EMPTY→FILL and latches mode.
  - On k=DEPTH-1 the bank goes FILL→FULL, the counter clears and the write pointer toggles.
- **Read side.**
  - When the read bank is FULL, it goes to DRAIN. Output index j runs 0..DEPTH-1.
  - Interleave: j = c*ROWS + r reads address r*COLS + c (row write, column read).
  - Deinterleave: j = r*COLS + c reads address c*ROWS + r, which is the exact inverse.
  - Addresses come from nested row/column counters; no multipliers are used.
  - After index DEPTH-1 is issued, the bank goes to EMPTY and the read pointer toggles.
- **Lane permutation.** When LANE_PERM=1, output lane i = stored lane bitrev(i) over log2(LANES) bits. It is self-inverse, so it is identical in both modes.
- **Output register.** A single output register holds each beat. A new read is issued only when the register is empty or is being accepted in the same cycle.
- **Simultaneous events.**
  - A bank going DRAIN→EMPTY and being written in the same cycle is legal; the write sees EMPTY.
  - Write completion and read start on different banks in the same cycle are independent.
- **Reset.** rst low at any time, mid-frame included, does the following:
  - both banks go to EMPTY; partial frames are discarded;
  - all counters and pointers clear;
  - out_valid=0, out_data=0, out_last=0;
  - in_ready=1 in the first cycle after reset.

## Timing
- Memory read latency is 1 cycle.
- Last beat of a frame accepted at cycle N, with the read side idle:
  - bank is FULL at N+1;
  - first read issued at N+1;
  - out_valid=1 at N+2.
- With continuous traffic and out_ready held high, output is one beat per cycle. There is no bubble between back-to-back frames.
- Backpressure:
  - out_valid stays asserted and out_data/out_last stay stable until accepted;
  - while stalled, the read counter holds.
- Both banks FULL/DRAIN forces in_ready=0. in_ready rises the cycle after the draining bank returns to EMPTY.
- Throughput is one beat per cycle sustained.

## Structure
- **Shared package turbo_pkg:**
  - bank-state enum {EMPTY, FILL, FULL, DRAIN};
  - MODE_INTERLEAVE / MODE_DEINTERLEAVE constants;
  - bitrev function.
- **Sub-module tbi_bank_ram:** simple dual-port RAM, DEPTH × LANES*W, registered read. Instantiate it twice.
- The top level holds:
  - write/read counters and bank state registers;
  - read-address generator;
  - lane permutation (combinational, on the read data);
  - output register.

## Test plan
- **Interleave:** W=30, LANES=4, ROWS=2, COLS=3, mode=0, beats b0..b5, out_ready=1.
  - Output order is b0, b3, b1, b4, b2, b5.
  - Lanes {A,B,C,D} come out as {A,C,B,D}.
  - out_last is high only on b5.
  - First out_valid is 2 cycles after b5 is accepted.
- **Deinterleave round-trip:** mode=1, input b0, b3, b1, b4, b2, b5 (taken from the interleave output) → output b0..b5 in natural order.
- **Back-to-back frames:** 3 frames, in_valid and out_ready held high → 18 consecutive output beats, no gaps, in_ready never low.
- **Backpressure:**
  - out_ready=0 for 20 cycles: in_ready drops after 2 full frames are held, and out_data stays stable.
  - Release: frames drain intact, in order.
- **Mid-frame reset:** rst pulled low after beat 3 of the second frame.
  - The next cycle shows out_valid=0, out_data=0, in_ready=1.
  - A fresh frame then interleaves correctly with no stale beats.
- **LANE_PERM=0, mode sampling:** LANE_PERM=0 gives lanes unpermuted. A mode toggle mid-frame has no effect; mode is taken from beat 0 only.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared types and helpers for the turbo decoder block interleaver.
package turbo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } bank_state_t;

  localparam logic MODE_INTERLEAVE   = 1'b0;
  localparam logic MODE_DEINTERLEAVE = 1'b1;

  function automatic int bitrev(input int val, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) begin
      if (val[i]) r = r | (1 << (bits - 1 - i));
    end
    return r;
  endfunction

endpackage

// File: rtl/tbi_bank_ram.sv
// One frame buffer: simple dual-port RAM with a registered read port.
module tbi_bank_ram #(
  parameter int DEPTH = 6,
  parameter int DW    = 120,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // rdata only moves on re, so it doubles as the held output beat.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/turbo_block_interleaver.sv
// Ping-pong row/column block interleaver/deinterleaver with bit-reversed lane
// permutation; one bank fills while the other drains.
module turbo_block_interleaver
  import turbo_pkg::*;
#(
  parameter int W         = 30,
  parameter int LANES     = 4,
  parameter int ROWS      = 2,
  parameter int COLS      = 3,
  parameter int LANE_PERM = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic               out_last
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW    = LANES * W;

  // Handshake: a beat moves on any rising clk where valid && ready; valid
  // never depends on ready, and a presented beat is held until taken.

  bank_state_t   bank_st  [2];
  bank_state_t   bank_nxt [2];
  logic          bank_mode [2];
  logic          wr_ptr, rd_ptr, out_bank, last_q;
  logic [AW-1:0] wr_cnt, rd_inner, rd_outer, rd_addr;
  logic [AW-1:0] inner_max, outer_max, step;
  logic          wr_fire, rd_issue, rd_last, rd_mode;
  logic [DW-1:0] rdata [2];
  logic [DW-1:0] rsel;

  assign in_ready = (bank_st[wr_ptr] == EMPTY) || (bank_st[wr_ptr] == FILL);
  assign wr_fire  = in_valid && in_ready;

  // Interleave walks rows fastest (stride COLS); deinterleave walks columns
  // fastest (stride ROWS). The outer counter restarts the address at outer+1.
  assign rd_mode   = bank_mode[rd_ptr];
  assign inner_max = (rd_mode == MODE_INTERLEAVE) ? AW'(ROWS - 1) : AW'(COLS - 1);
  assign outer_max = (rd_mode == MODE_INTERLEAVE) ? AW'(COLS - 1) : AW'(ROWS - 1);
  assign step      = (rd_mode == MODE_INTERLEAVE) ? AW'(COLS) : AW'(ROWS);

  assign rd_issue = ((bank_st[rd_ptr] == FULL) || (bank_st[rd_ptr] == DRAIN)) &&
                    (!out_valid || out_ready);
  assign rd_last  = (rd_inner == inner_max) && (rd_outer == outer_max);

  always_comb begin
    bank_nxt[0] = bank_st[0];
    bank_nxt[1] = bank_st[1];
    // Read side only touches FULL/DRAIN banks, write side only EMPTY/FILL.
    if (rd_issue) bank_nxt[rd_ptr] = rd_last ? EMPTY : DRAIN;
    if (wr_fire)  bank_nxt[wr_ptr] = (wr_cnt == AW'(DEPTH - 1)) ? FULL : FILL;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_st[0]   <= EMPTY;
      bank_st[1]   <= EMPTY;
      bank_mode[0] <= MODE_INTERLEAVE;
      bank_mode[1] <= MODE_INTERLEAVE;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      wr_cnt       <= '0;
      rd_inner     <= '0;
      rd_outer     <= '0;
      rd_addr      <= '0;
      out_valid    <= 1'b0;
      out_bank     <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      bank_st[0] <= bank_nxt[0];
      bank_st[1] <= bank_nxt[1];
      if (wr_fire) begin
        if (wr_cnt == '0) bank_mode[wr_ptr] <= mode;
        if (wr_cnt == AW'(DEPTH - 1)) begin
          wr_cnt <= '0;
          wr_ptr <= ~wr_ptr;
        end else begin
          wr_cnt <= wr_cnt + AW'(1);
        end
      end
      if (rd_issue) begin
        out_bank <= rd_ptr;
        last_q   <= rd_last;
        if (rd_last) begin
          rd_inner <= '0;
          rd_outer <= '0;
          rd_addr  <= '0;
          rd_ptr   <= ~rd_ptr;
        end else if (rd_inner == inner_max) begin
          rd_inner <= '0;
          rd_outer <= rd_outer + AW'(1);
          rd_addr  <= rd_outer + AW'(1);
        end else begin
          rd_inner <= rd_inner + AW'(1);
          rd_addr  <= rd_addr + step;
        end
      end
      if (rd_issue)       out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tbi_bank_ram #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (wr_fire && (wr_ptr == 1'(b))),
      .waddr (wr_cnt),
      .wdata (in_data),
      .re    (rd_issue && (rd_ptr == 1'(b))),
      .raddr (rd_addr),
      .rdata (rdata[b])
    );
  end

  assign rsel     = rdata[out_bank];
  assign out_last = out_valid && last_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int SRC = (LANE_PERM != 0) ? bitrev(i, $clog2(LANES)) : i;
    assign out_data[i*W +: W] = out_valid ? rsel[SRC*W +: W] : '0;
  end

endmodule
